// File: rtl/sub_shift_rows.sv
// Iterative AES SubBytes + ShiftRows, NUM_SBOX bytes substituted per cycle, valid/ready on both sides.
// Define SUB_SHIFT_INV_EN to add the inv port (InvSubBytes + InvShiftRows selected per state).
module sub_shift_rows #(
    parameter int unsigned NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SUB_SHIFT_INV_EN
    input  logic         inv,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 && NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
        $error("sub_shift_rows: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    localparam int unsigned GROUPS = 16 / NUM_SBOX;
    localparam logic [3:0]  LAST   = 4'(GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       cnt_q;
    logic [3:0]       base;
    logic [0:15][7:0] st_q;
    logic [0:15][7:0] st_d;
    logic [127:0]     out_q;
    logic             mode_inv;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

`ifdef SUB_SHIFT_INV_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction
`endif

    // Byte index is row + 4*col; forward rotates row r left by r, inverse right by r.
    function automatic logic [0:15][7:0] shift_rows(input logic [0:15][7:0] s, input logic dir_inv);
        logic [0:15][7:0] o;
        int unsigned      src;
        o = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                src = dir_inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
                o[4'(r + 4 * c)] = s[4'(r + 4 * src)];
            end
        end
        return o;
    endfunction

    always_comb begin
        base = 4'(cnt_q * NUM_SBOX);
        st_d = st_q;
        for (int unsigned j = 0; j < NUM_SBOX; j++) begin
`ifdef SUB_SHIFT_INV_EN
            st_d[base + 4'(j)] = mode_inv ? sbox_inv(st_q[base + 4'(j)]) : sbox_fwd(st_q[base + 4'(j)]);
`else
            st_d[base + 4'(j)] = sbox_fwd(st_q[base + 4'(j)]);
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_d = SUB;
            end
            SUB: begin
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef SUB_SHIFT_INV_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (state_q == IDLE && in_valid && in_ready) begin
            inv_q <= inv;
        end
    end

    assign mode_inv = inv_q;
`else
    assign mode_inv = 1'b0;
`endif

    // The last group's substitution is folded into the DONE-entry register so out_data is valid on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            st_q  <= '0;
            out_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        st_q  <= in_data;
                        cnt_q <= '0;
                    end
                end
                SUB: begin
                    st_q <= st_d;
                    if (cnt_q == LAST) begin
                        out_q <= shift_rows(st_d, mode_inv);
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = out_q;

endmodule

// File: tb/tb_sub_shift_rows.sv
// Scoreboard bench for sub_shift_rows at NUM_SBOX = 4 (main), 1 and 16.
`timescale 1ns/1ps
module tb_sub_shift_rows;

    localparam logic [127:0] R1_IN    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] R1_OUT   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] R2_IN    = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] R2_OUT   = 128'h49db873b453953897f02d2f177de961a;
    localparam logic [127:0] ZERO_OUT = {16{8'h63}};

    typedef struct {
        int           sel;
        logic [127:0] d;
        longint       t_rise;
        longint       t_hs;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   iv;
    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [2:0]   ordy;
    logic [127:0] id [3];
    logic [127:0] od [3];
`ifdef SUB_SHIFT_INV_EN
    logic [2:0]   inv_s;
`endif

    ev_t          acc_q [$];
    ev_t          out_q [$];
    logic [127:0] exp_q [$];
    longint       rise_t [3];
    int           rises [3];
    logic [2:0]   ov_prev = '0;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    sub_shift_rows #(.NUM_SBOX(4)) u_dut4 (
        .clk(clk), .rst(rst),
`ifdef SUB_SHIFT_INV_EN
        .inv(inv_s[0]),
`endif
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0])
    );

    sub_shift_rows #(.NUM_SBOX(1)) u_dut1 (
        .clk(clk), .rst(rst),
`ifdef SUB_SHIFT_INV_EN
        .inv(inv_s[1]),
`endif
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1])
    );

    sub_shift_rows #(.NUM_SBOX(16)) u_dut16 (
        .clk(clk), .rst(rst),
`ifdef SUB_SHIFT_INV_EN
        .inv(inv_s[2]),
`endif
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2])
    );

    // Inputs only change 1ns after a rising edge, so the falling edge sees what the next rising edge will.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ov[k] === 1'b1 && ov_prev[k] !== 1'b1) begin
                rise_t[k] = $time - 5;
                rises[k]  = rises[k] + 1;
            end
            if (rst === 1'b0 && iv[k] === 1'b1 && ir[k] === 1'b1) begin
                ev_t e;
                e.sel = k; e.d = id[k]; e.t_rise = 0; e.t_hs = $time + 5;
                acc_q.push_back(e);
            end
            if (rst === 1'b0 && ov[k] === 1'b1 && ordy[k] === 1'b1) begin
                ev_t e;
                e.sel = k; e.d = od[k]; e.t_rise = rise_t[k]; e.t_hs = $time + 5;
                out_q.push_back(e);
            end
        end
        ov_prev = ov;
    end

    function automatic int ns_of(input int sel);
        case (sel)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int sel, input logic [127:0] data, output longint t_acc, output bit ok);
        iv[sel] = 1'b1;
        id[sel] = data;
        ok      = 1'b0;
        t_acc   = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick(1);
            if (acc_q.size() > 0) begin
                ev_t e;
                e     = acc_q.pop_front();
                t_acc = e.t_hs;
                ok    = 1'b1;
            end
        end
        iv[sel] = 1'b0;
    endtask

    task automatic get_out(output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{sel: -1, d: '0, t_rise: 0, t_hs: 0};
        for (int i = 0; i < 80 && !ok; i++) begin
            if (out_q.size() > 0) begin
                e  = out_q.pop_front();
                ok = 1'b1;
            end else begin
                tick(1);
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        iv   = '0;
        ordy = '1;
        for (int k = 0; k < 3; k++) id[k] = '0;
`ifdef SUB_SHIFT_INV_EN
        inv_s = '0;
`endif
        tick(3);
        n_cmp++;
        if (ir !== 3'b000) begin n_err++; $display("FAIL reset_in_ready_low: got %b, expected 000", ir); end
        n_cmp++;
        if (ov !== 3'b000) begin n_err++; $display("FAIL reset_out_valid: got %b, expected 000", ov); end
        rst = 1'b0;
        tick(1);
        n_cmp++;
        if (ir !== 3'b111) begin n_err++; $display("FAIL idle_in_ready: got %b, expected 111", ir); end
        n_cmp++;
        if (ov !== 3'b000) begin n_err++; $display("FAIL idle_out_valid: got %b, expected 000", ov); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (od[k] !== 128'h0) begin n_err++; $display("FAIL idle_out_data[%0d]: got %h, expected 0", k, od[k]); end
        end
    endtask

    task automatic test_vectors();
        logic [127:0] vin  [2];
        logic [127:0] vout [2];
        longint       t_acc;
        bit           ok;
        ev_t          e;
        logic [127:0] x;
        vin[0] = R1_IN;  vout[0] = R1_OUT;
        vin[1] = R2_IN;  vout[1] = R2_OUT;
        for (int v = 0; v < 2; v++) begin
            exp_q.push_back(vout[v]);
            send(0, vin[v], t_acc, ok);
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL vec%0d_accept: got no handshake, expected one", v); end
            n_cmp++;
            if (ir[0] !== 1'b0 || ov[0] !== 1'b0) begin
                n_err++; $display("FAIL vec%0d_busy: got in_ready=%b out_valid=%b, expected 0 0", v, ir[0], ov[0]);
            end
            get_out(e, ok);
            x = exp_q.pop_front();
            n_cmp++;
            if (!ok || e.sel != 0 || e.d !== x) begin
                n_err++; $display("FAIL vec%0d_data: got %h (sel %0d), expected %h", v, e.d, e.sel, x);
            end
            n_cmp++;
            if ((e.t_rise - t_acc) / 10 != 4) begin
                n_err++; $display("FAIL vec%0d_latency: got %0d, expected 4", v, (e.t_rise - t_acc) / 10);
            end
        end
    endtask

    task automatic test_zero_all_widths();
        longint       t_acc;
        bit           ok;
        ev_t          e;
        logic [127:0] x;
        for (int s = 0; s < 3; s++) begin
            exp_q.push_back(ZERO_OUT);
            send(s, 128'h0, t_acc, ok);
            get_out(e, ok);
            x = exp_q.pop_front();
            n_cmp++;
            if (!ok || e.sel != s || e.d !== x) begin
                n_err++; $display("FAIL zero_data_ns%0d: got %h (sel %0d), expected %h", ns_of(s), e.d, e.sel, x);
            end
            n_cmp++;
            if ((e.t_rise - t_acc) / 10 != longint'(16 / ns_of(s))) begin
                n_err++; $display("FAIL zero_latency_ns%0d: got %0d, expected %0d", ns_of(s), (e.t_rise - t_acc) / 10, 16 / ns_of(s));
            end
        end
    endtask

    task automatic test_backpressure();
        longint       t_acc;
        bit           ok;
        ev_t          e;
        logic [127:0] x;
        ordy[0] = 1'b0;
        exp_q.push_back(R1_OUT);
        send(0, R1_IN, t_acc, ok);
        for (int i = 0; i < 20 && ov[0] !== 1'b1; i++) tick(1);
        n_cmp++;
        if (ov[0] !== 1'b1) begin n_err++; $display("FAIL stall_out_valid: got %b, expected 1", ov[0]); end
        for (int c = 0; c < 10; c++) begin
            if (c == 2) begin
                iv[0] = 1'b1;
                id[0] = R2_IN;
            end
            tick(1);
            n_cmp++;
            if (od[0] !== R1_OUT || ov[0] !== 1'b1) begin
                n_err++; $display("FAIL stall_hold_%0d: got %h valid %b, expected %h valid 1", c, od[0], ov[0], R1_OUT);
            end
            n_cmp++;
            if (ir[0] !== 1'b0) begin n_err++; $display("FAIL stall_in_ready_%0d: got %b, expected 0", c, ir[0]); end
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        get_out(e, ok);
        x = exp_q.pop_front();
        n_cmp++;
        if (!ok || e.d !== x) begin n_err++; $display("FAIL stall_release_data: got %h, expected %h", e.d, x); end
        n_cmp++;
        if (acc_q.size() != 0) begin n_err++; $display("FAIL stall_no_capture: got %0d accepts, expected 0", acc_q.size()); end
        tick(2);
        n_cmp++;
        if (ir[0] !== 1'b1 || out_q.size() != 0) begin
            n_err++; $display("FAIL stall_after: got in_ready=%b extra_out=%0d, expected 1 0", ir[0], out_q.size());
        end
    endtask

    task automatic test_back_to_back();
        longint       t1;
        longint       t2;
        bit           ok1;
        bit           ok2;
        ev_t          e1;
        ev_t          e2;
        logic [127:0] x;
        ordy[0] = 1'b1;
        exp_q.push_back(R1_OUT);
        exp_q.push_back(ZERO_OUT);
        iv[0] = 1'b1;
        id[0] = R1_IN;
        t1 = 0; t2 = 0; ok1 = 0; ok2 = 0;
        for (int i = 0; i < 20 && !ok1; i++) begin
            tick(1);
            if (acc_q.size() > 0) begin ev_t a; a = acc_q.pop_front(); t1 = a.t_hs; ok1 = 1'b1; end
        end
        id[0] = 128'h0;
        for (int i = 0; i < 20 && !ok2; i++) begin
            tick(1);
            if (acc_q.size() > 0) begin ev_t a; a = acc_q.pop_front(); t2 = a.t_hs; ok2 = 1'b1; end
        end
        iv[0] = 1'b0;
        n_cmp++;
        if (!ok1 || !ok2 || (t2 - t1) / 10 != 6) begin
            n_err++; $display("FAIL b2b_accept_gap: got %0d cycles (ok %b%b), expected 6", (t2 - t1) / 10, ok1, ok2);
        end
        get_out(e1, ok1);
        x = exp_q.pop_front();
        n_cmp++;
        if (!ok1 || e1.d !== x) begin n_err++; $display("FAIL b2b_first: got %h, expected %h", e1.d, x); end
        get_out(e2, ok2);
        x = exp_q.pop_front();
        n_cmp++;
        if (!ok2 || e2.d !== x) begin n_err++; $display("FAIL b2b_second: got %h, expected %h", e2.d, x); end
        n_cmp++;
        if ((e2.t_rise - e1.t_rise) / 10 != 6) begin
            n_err++; $display("FAIL b2b_output_gap: got %0d, expected 6", (e2.t_rise - e1.t_rise) / 10);
        end
    endtask

    task automatic test_reset_mid_sub();
        longint t_acc;
        bit     ok;
        int     r0;
        r0 = rises[0];
        send(0, R1_IN, t_acc, ok);
        rst = 1'b1;
        tick(1);
        n_cmp++;
        if (ir[0] !== 1'b0 || ov[0] !== 1'b0) begin
            n_err++; $display("FAIL midrst_during: got in_ready=%b out_valid=%b, expected 0 0", ir[0], ov[0]);
        end
        rst = 1'b0;
        tick(1);
        n_cmp++;
        if (ir[0] !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b, expected 1", ir[0]); end
        tick(20);
        n_cmp++;
        if (rises[0] != r0 || out_q.size() != 0) begin
            n_err++; $display("FAIL midrst_no_output: got %0d rises %0d outputs, expected 0 0", rises[0] - r0, out_q.size());
        end
    endtask

`ifdef SUB_SHIFT_INV_EN
    task automatic test_inv();
        longint       t_acc;
        bit           ok;
        ev_t          e;
        logic [127:0] x;
        inv_s[0] = 1'b1;
        exp_q.push_back(R1_IN);
        send(0, R1_OUT, t_acc, ok);
        inv_s[0] = 1'b0;
        get_out(e, ok);
        x = exp_q.pop_front();
        n_cmp++;
        if (!ok || e.d !== x) begin n_err++; $display("FAIL inv_r1_data: got %h, expected %h", e.d, x); end
        n_cmp++;
        if ((e.t_rise - t_acc) / 10 != 4) begin
            n_err++; $display("FAIL inv_latency: got %0d, expected 4", (e.t_rise - t_acc) / 10);
        end
        inv_s[0] = 1'b1;
        exp_q.push_back(R2_IN);
        send(0, R2_OUT, t_acc, ok);
        get_out(e, ok);
        x = exp_q.pop_front();
        n_cmp++;
        if (!ok || e.d !== x) begin n_err++; $display("FAIL inv_r2_data: got %h, expected %h", e.d, x); end
        inv_s[0] = 1'b0;
        exp_q.push_back(R2_OUT);
        send(0, R2_IN, t_acc, ok);
        get_out(e, ok);
        x = exp_q.pop_front();
        n_cmp++;
        if (!ok || e.d !== x) begin n_err++; $display("FAIL inv_fwd_again: got %h, expected %h", e.d, x); end
    endtask
`endif

    initial begin
        for (int k = 0; k < 3; k++) begin
            rise_t[k] = 0;
            rises[k]  = 0;
        end
        test_reset();
        test_vectors();
        test_zero_all_widths();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_sub();
`ifdef SUB_SHIFT_INV_EN
        test_inv();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000ns, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
